nibble_accumulator: RTL

NIBBLE_ACCUMULATOR -- requirements
Module: nibble_accumulator

---
 rtl/nibble_accumulator.sv | 138 +++++++++++++
 1 files changed

// File: rtl/nibble_accumulator.sv
// -----------------------------------------------------------------------------
// nibble_accumulator
//
// Sums NSAMP unsigned 4-bit samples into an 8-bit frame total, using a single
// 4-bit add-with-carry stage shared between the low and high nibble of the
// accumulator. Each sample takes three cycles (IDLE accept, LOW add, HIGH
// carry ripple). After the last sample of a frame the result is presented in
// DONE until downstream takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream sample valid
//   in_ready   block can accept a sample this cycle (IDLE only)
//   in_data    4-bit unsigned sample
//   out_valid  frame result valid (DONE only)
//   out_ready  downstream accepts the result
//   out_sum    frame sum modulo 256 (tracks the accumulator in every state)
//   out_ovf    sticky flag: frame sum exceeded 255
// -----------------------------------------------------------------------------
module nibble_accumulator #(
    parameter int NSAMP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sum,
    output logic       out_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_acc;
    logic [3:0] r_sample;
    logic       r_carry;
    logic       r_ovf;
    logic [7:0] r_count;
    logic       r_run;

    logic [3:0] w_add_a;
    logic [3:0] w_add_b;
    logic       w_add_cin;
    logic [4:0] w_add_res;
    logic       w_last;
    logic       w_accept;

    // The one shared nibble adder: {cout, sum} = a + b + cin.
    function automatic logic [4:0] add4c(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic       cin);
        return {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    endfunction

    // r_run holds in_ready low through reset and until the first clock edge
    // after reset is released.
    assign in_ready  = (r_state == IDLE) && r_run;
    assign w_accept  = in_ready && in_valid;
    assign out_valid = (r_state == DONE);
    assign out_sum   = r_acc;
    assign out_ovf   = r_ovf;
    assign w_last    = (r_count == 8'(NSAMP - 1));

    // Operand steering: LOW adds the sample into the low nibble, HIGH ripples
    // the saved carry into the high nibble.
    always_comb begin
        w_add_a   = r_acc[3:0];
        w_add_b   = r_sample;
        w_add_cin = 1'b0;
        if (r_state == HIGH) begin
            w_add_a   = r_acc[7:4];
            w_add_b   = 4'b0000;
            w_add_cin = r_carry;
        end
    end

    assign w_add_res = add4c(w_add_a, w_add_b, w_add_cin);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = LOW;
            LOW:     w_state_nxt = HIGH;
            HIGH:    w_state_nxt = w_last ? DONE : IDLE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_acc    <= 8'h00;
            r_sample <= 4'h0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_count  <= 8'h00;
            r_run    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) r_sample <= in_data;
                end
                LOW: begin
                    r_acc[3:0] <= w_add_res[3:0];
                    r_carry    <= w_add_res[4];
                end
                HIGH: begin
                    r_acc[7:4] <= w_add_res[3:0];
                    // Overflow is sticky for the rest of the frame.
                    if (w_add_res[4]) r_ovf <= 1'b1;
                    if (!w_last) r_count <= r_count + 8'd1;
                end
                DONE: begin
                    if (out_ready) begin
                        r_acc   <= 8'h00;
                        r_ovf   <= 1'b0;
                        r_count <= 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
